fwd_lookup_ctrl: RTL and testbench

// Requester side of the address_table learn/read interface. Accepts one parsed frame-header

---
 rtl/fwd_lookup_ctrl_if.sv | 41 ++++
 rtl/fwd_lookup_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_lookup_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_lookup_ctrl_if.sv
// Signal bundle between fwd_lookup_ctrl, the header parser, the address table and the queue manager.
// The master modport is the controller's own view of the bundle.
interface fwd_lookup_ctrl_if #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                 hdr_valid;
  logic                 hdr_ready;
  logic [47:0]          hdr_src_mac;
  logic [47:0]          hdr_dst_mac;
  logic [PW-1:0]        hdr_port;
  logic                 learn_req;
  logic [47:0]          learn_address;
  logic [PW-1:0]        learn_port;
  logic                 read_req;
  logic [47:0]          read_address;
  logic [PW-1:0]        read_port;
  logic                 read_port_valid;
  logic                 dec_valid;
  logic                 dec_ready;
  logic [NUM_PORTS-1:0] dec_mask;
  logic                 dec_flood;
  logic                 dec_drop;
  logic [CNT_W-1:0]     stat_hit_cnt;
  logic [CNT_W-1:0]     stat_miss_cnt;
  logic [CNT_W-1:0]     stat_flood_cnt;

  modport master (
    input  hdr_valid, hdr_src_mac, hdr_dst_mac, hdr_port, read_port, read_port_valid, dec_ready,
    output hdr_ready, learn_req, learn_address, learn_port, read_req, read_address,
           dec_valid, dec_mask, dec_flood, dec_drop, stat_hit_cnt, stat_miss_cnt, stat_flood_cnt
  );

  modport slave (
    output hdr_valid, hdr_src_mac, hdr_dst_mac, hdr_port, read_port, read_port_valid, dec_ready,
    input  hdr_ready, learn_req, learn_address, learn_port, read_req, read_address,
           dec_valid, dec_mask, dec_flood, dec_drop, stat_hit_cnt, stat_miss_cnt, stat_flood_cnt
  );
endinterface

// File: rtl/fwd_lookup_ctrl.sv
// Forwarding lookup controller: learns the source MAC, looks up the destination MAC and
// returns a unicast / flood / drop decision, one header at a time.
module fwd_lookup_ctrl #(
  parameter int NUM_PORTS    = 4,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  fwd_lookup_ctrl_if.master bus
);
  localparam int                   PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [2:0]           RL  = 3'(READ_LATENCY);
  localparam logic [PW:0]          NP  = (PW + 1)'(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  typedef enum logic [2:0] {IDLE, LEARN, READ, WAIT, RESP} state_t;

  state_t               state;
  logic [2:0]           lat_cnt;
  logic                 sample_now;
  logic                 port_ok;
  logic                 lk_drop;
  logic                 lk_flood;
  logic [NUM_PORTS-1:0] lk_mask;
  logic [NUM_PORTS-1:0] flood_mask;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Lookup result decoded against the captured ingress port; only used when sample_now is high.
  always_comb begin
    flood_mask = ~(ONE << bus.learn_port);
    port_ok    = bus.read_port_valid && ({1'b0, bus.read_port} < NP);
    lk_drop    = port_ok && (bus.read_port == bus.learn_port);
    lk_flood   = !port_ok;
    lk_mask    = '0;
    if (lk_flood)
      lk_mask = flood_mask;
    else if (!lk_drop)
      lk_mask = ONE << bus.read_port;
    sample_now = ((state == READ) && (RL == 3'd0)) || ((state == WAIT) && (lat_cnt == 3'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      lat_cnt            <= '0;
      bus.hdr_ready      <= 1'b1;
      bus.learn_req      <= 1'b0;
      bus.learn_address  <= '0;
      bus.learn_port     <= '0;
      bus.read_req       <= 1'b0;
      bus.read_address   <= '0;
      bus.dec_valid      <= 1'b0;
      bus.dec_mask       <= '0;
      bus.dec_flood      <= 1'b0;
      bus.dec_drop       <= 1'b0;
      bus.stat_hit_cnt   <= '0;
      bus.stat_miss_cnt  <= '0;
      bus.stat_flood_cnt <= '0;
    end else begin
      bus.learn_req <= 1'b0;
      bus.read_req  <= 1'b0;
      case (state)
        IDLE: if (bus.hdr_valid) begin
          bus.learn_address <= bus.hdr_src_mac;
          bus.learn_port    <= bus.hdr_port;
          bus.read_address  <= bus.hdr_dst_mac;
          bus.learn_req     <= !bus.hdr_src_mac[40];
          bus.hdr_ready     <= 1'b0;
          state             <= LEARN;
        end
        LEARN: if (bus.read_address[40]) begin
          bus.dec_valid      <= 1'b1;
          bus.dec_mask       <= flood_mask;
          bus.dec_flood      <= 1'b1;
          bus.dec_drop       <= 1'b0;
          bus.stat_flood_cnt <= sat_inc(bus.stat_flood_cnt);
          state              <= RESP;
        end else begin
          bus.read_req <= 1'b1;
          state        <= READ;
        end
        READ: begin
          lat_cnt <= RL;
          state   <= WAIT;
        end
        WAIT: lat_cnt <= lat_cnt - 3'd1;
        RESP: if (bus.dec_ready) begin
          bus.dec_valid <= 1'b0;
          bus.dec_mask  <= '0;
          bus.dec_flood <= 1'b0;
          bus.dec_drop  <= 1'b0;
          bus.hdr_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A hit naming a nonexistent port carries no usable entry, so it is counted as a miss.
      if (sample_now) begin
        bus.dec_valid <= 1'b1;
        bus.dec_mask  <= lk_mask;
        bus.dec_flood <= lk_flood;
        bus.dec_drop  <= lk_drop;
        if (port_ok) begin
          bus.stat_hit_cnt <= sat_inc(bus.stat_hit_cnt);
        end else begin
          bus.stat_miss_cnt  <= sat_inc(bus.stat_miss_cnt);
          bus.stat_flood_cnt <= sat_inc(bus.stat_flood_cnt);
        end
        state <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_fwd_lookup_ctrl.sv
// Bench for fwd_lookup_ctrl: address-table stubs driven by MAC tables, and a forwarding
// reference model predicting decision, strobes, latency and statistics per header.
module tb_fwd_lookup_ctrl;
  localparam int NP  = 4;
  localparam int CW  = 16;
  localparam int RL1 = 1;
  localparam int RL2 = 3;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  fwd_lookup_ctrl_if #(.NUM_PORTS(NP), .CNT_W(CW)) b1 ();
  fwd_lookup_ctrl_if #(.NUM_PORTS(NP), .CNT_W(CW)) b2 ();

  fwd_lookup_ctrl #(.NUM_PORTS(NP), .READ_LATENCY(RL1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.master));
  fwd_lookup_ctrl #(.NUM_PORTS(NP), .READ_LATENCY(RL2), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(b2.master));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address-table stubs: the true result is presented only in the cycle READ_LATENCY after
  // read_req; every other cycle shows the opposite result so a mistimed sample is visible.
  logic [1:0] tbl1 [logic [47:0]];
  logic [1:0] tbl2 [logic [47:0]];
  int         k1 = 99, k2 = 99;
  logic       hit1 = 1'b0, hit2 = 1'b0;
  logic [1:0] pt1 = 2'd0, pt2 = 2'd0;

  always @(negedge clk) begin
    if (b1.learn_req) tbl1[b1.learn_address] = b1.learn_port;
    if (b1.read_req) begin
      k1   = 0;
      hit1 = (tbl1.exists(b1.read_address) != 0);
      pt1  = hit1 ? tbl1[b1.read_address] : 2'd0;
    end else if (k1 < 99) k1++;
    b1.read_port_valid = (k1 == RL1) ? hit1 : !hit1;
    b1.read_port       = (k1 == RL1) ? pt1 : pt1 + 2'd1;
  end

  always @(negedge clk) begin
    if (b2.learn_req) tbl2[b2.learn_address] = b2.learn_port;
    if (b2.read_req) begin
      k2   = 0;
      hit2 = (tbl2.exists(b2.read_address) != 0);
      pt2  = hit2 ? tbl2[b2.read_address] : 2'd0;
    end else if (k2 < 99) k2++;
    b2.read_port_valid = (k2 == RL2) ? hit2 : !hit2;
    b2.read_port       = (k2 == RL2) ? pt2 : pt2 + 2'd1;
  end

  // Reference model state
  logic [1:0]    mtbl [logic [47:0]];
  int            m_hit = 0, m_miss = 0, m_flood = 0;
  logic [NP-1:0] last_mask;
  logic          last_flood, last_drop;
  logic [47:0]   pool [8];

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic run_hdr(input logic [47:0] src, input logic [47:0] dst, input logic [1:0] port,
                         input int hold);
    logic [NP-1:0] e_mask, all_but;
    logic          e_flood, e_drop;
    int            e_lat, e_learn, e_read, n, nl, nr;
    all_but = ~(4'b0001 << port);
    e_mask  = '0;
    e_flood = 1'b0;
    e_drop  = 1'b0;
    e_learn = src[40] ? 0 : 1;
    e_read  = dst[40] ? 0 : 1;
    if (!src[40]) mtbl[src] = port;
    if (dst[40]) begin
      e_lat   = 1;
      e_flood = 1'b1;
      e_mask  = all_but;
      m_flood = sat(m_flood);
    end else begin
      e_lat = 2 + RL1;
      if (mtbl.exists(dst) != 0) begin
        m_hit = sat(m_hit);
        if (mtbl[dst] == port) e_drop = 1'b1;
        else e_mask = 4'b0001 << mtbl[dst];
      end else begin
        e_flood = 1'b1;
        e_mask  = all_but;
        m_miss  = sat(m_miss);
        m_flood = sat(m_flood);
      end
    end

    check_eq("hdr_ready_idle", b1.hdr_ready, 1);
    b1.hdr_src_mac = src;
    b1.hdr_dst_mac = dst;
    b1.hdr_port    = port;
    b1.hdr_valid   = 1'b1;
    @(posedge clk); #1;
    b1.hdr_valid = 1'b0;
    check_eq("learn_address", b1.learn_address, src);
    check_eq("learn_port", b1.learn_port, port);
    check_eq("read_address", b1.read_address, dst);

    n = 0; nl = 0; nr = 0;
    while (!b1.dec_valid && n < 40) begin
      nl += int'(b1.learn_req);
      nr += int'(b1.read_req);
      @(posedge clk); #1;
      n++;
    end
    check_eq("dec_latency", n, e_lat);
    check_eq("learn_strobes", nl, e_learn);
    check_eq("read_strobes", nr, e_read);
    check_eq("dec_mask", b1.dec_mask, e_mask);
    check_eq("dec_flood", b1.dec_flood, e_flood);
    check_eq("dec_drop", b1.dec_drop, e_drop);
    check_eq("hit_cnt", b1.stat_hit_cnt, m_hit);
    check_eq("miss_cnt", b1.stat_miss_cnt, m_miss);
    check_eq("flood_cnt", b1.stat_flood_cnt, m_flood);
    last_mask  = b1.dec_mask;
    last_flood = b1.dec_flood;
    last_drop  = b1.dec_drop;

    // Backpressure: a competing header is offered but must not be captured.
    for (int h = 0; h < hold; h++) begin
      b1.hdr_src_mac = 48'h0000_0000_7777;
      b1.hdr_dst_mac = 48'h0000_0000_8888;
      b1.hdr_port    = 2'd0;
      b1.hdr_valid   = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_dec_valid", b1.dec_valid, 1);
      check_eq("bp_dec_mask", b1.dec_mask, e_mask);
      check_eq("bp_dec_flood", b1.dec_flood, e_flood);
      check_eq("bp_hdr_ready", b1.hdr_ready, 0);
      check_eq("bp_no_capture", b1.learn_address, src);
    end
    b1.hdr_valid = 1'b0;
    b1.dec_ready = 1'b1;
    @(posedge clk); #1;
    b1.dec_ready = 1'b0;
    check_eq("post_accept_valid", b1.dec_valid, 0);
    check_eq("post_accept_ready", b1.hdr_ready, 1);
  endtask

  task automatic run2(input logic [47:0] src, input logic [47:0] dst, input logic [1:0] port,
                      input logic [NP-1:0] e_mask, input string tag);
    int n, rd_at;
    b2.hdr_src_mac = src;
    b2.hdr_dst_mac = dst;
    b2.hdr_port    = port;
    b2.hdr_valid   = 1'b1;
    @(posedge clk); #1;
    b2.hdr_valid = 1'b0;
    n = 0; rd_at = -100;
    while (!b2.dec_valid && n < 40) begin
      if (b2.read_req) rd_at = n;
      @(posedge clk); #1;
      n++;
    end
    // Result sampled at the end of the cycle RL2 after read_req, visible one edge later.
    check_eq({tag, "_req_to_dec"}, n - rd_at, RL2 + 1);
    check_eq({tag, "_mask"}, b2.dec_mask, e_mask);
    b2.dec_ready = 1'b1;
    @(posedge clk); #1;
    b2.dec_ready = 1'b0;
  endtask

  initial begin
    int seen;
    b1.hdr_valid = 1'b0; b1.hdr_src_mac = '0; b1.hdr_dst_mac = '0; b1.hdr_port = '0;
    b1.dec_ready = 1'b0;
    b2.hdr_valid = 1'b0; b2.hdr_src_mac = '0; b2.hdr_dst_mac = '0; b2.hdr_port = '0;
    b2.dec_ready = 1'b0;
    pool[0] = 48'h0000_0000_3001; pool[1] = 48'h0000_0000_3002;
    pool[2] = 48'h0000_0000_3003; pool[3] = 48'h0000_0000_3004;
    pool[4] = 48'h0000_0000_3005; pool[5] = 48'h0000_0000_3006;
    pool[6] = 48'h0100_0000_0001; pool[7] = 48'hFFFF_FFFF_FFFF;

    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_hdr_ready", b1.hdr_ready, 1);
    check_eq("rst_dec_valid", b1.dec_valid, 0);
    check_eq("rst_learn_req", b1.learn_req, 0);
    check_eq("rst_read_req", b1.read_req, 0);
    check_eq("rst_hit_cnt", b1.stat_hit_cnt, 0);
    check_eq("rst_miss_cnt", b1.stat_miss_cnt, 0);
    check_eq("rst_flood_cnt", b1.stat_flood_cnt, 0);
    check_eq("rst2_hdr_ready", b2.hdr_ready, 1);
    check_eq("rst2_dec_valid", b2.dec_valid, 0);

    run_hdr(48'h0000_0000_1001, 48'h0000_0000_1002, 2'd2, 0);
    check_eq("dir_miss_mask", last_mask, 4'b1011);
    check_eq("dir_miss_flood", last_flood, 1);
    run_hdr(48'h0000_0000_1002, 48'h0000_0000_1001, 2'd1, 0);
    check_eq("dir_hit_mask", last_mask, 4'b0100);
    check_eq("dir_hit_cnt", b1.stat_hit_cnt, 1);
    run_hdr(48'h0000_0000_1003, 48'hFFFF_FFFF_FFFF, 2'd0, 0);
    check_eq("dir_bcast_mask", last_mask, 4'b1110);
    check_eq("dir_bcast_flood", last_flood, 1);
    run_hdr(48'h0000_0000_1005, 48'h0000_0000_1005, 2'd3, 0);
    check_eq("dir_drop", last_drop, 1);
    check_eq("dir_drop_mask", last_mask, 4'b0000);
    run_hdr(48'h0000_0000_1006, 48'h0000_0000_1001, 2'd0, 10);
    check_eq("dir_bp_mask", last_mask, 4'b0100);

    for (int i = 0; i < 60; i++) begin
      logic [47:0] s, d;
      s = pool[$urandom_range(0, 7)];
      d = pool[$urandom_range(0, 7)];
      run_hdr(s, d, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    run2(48'h0000_0000_2002, 48'h0000_0000_2001, 2'd3, 4'b0111, "rl3_miss");
    run2(48'h0000_0000_2001, 48'h0000_0000_2002, 2'd1, 4'b1000, "rl3_hit");

    // Abort a lookup while waiting for the table.
    b2.hdr_src_mac = 48'h0000_0000_2003;
    b2.hdr_dst_mac = 48'h0000_0000_2002;
    b2.hdr_port    = 2'd0;
    b2.hdr_valid   = 1'b1;
    @(posedge clk); #1;
    b2.hdr_valid = 1'b0;
    seen = 0;
    while (!b2.read_req && seen < 10) begin
      @(posedge clk); #1;
      seen++;
    end
    check_eq("abort_read_req_seen", b2.read_req, 1);
    @(posedge clk); #1;
    rst2_n = 1'b0;
    #1;
    check_eq("abort_hdr_ready", b2.hdr_ready, 1);
    check_eq("abort_dec_valid", b2.dec_valid, 0);
    check_eq("abort_read_req", b2.read_req, 0);
    check_eq("abort_learn_req", b2.learn_req, 0);
    check_eq("abort_dec_mask", b2.dec_mask, 0);
    check_eq("abort_hit_cnt", b2.stat_hit_cnt, 0);
    check_eq("abort_flood_cnt", b2.stat_flood_cnt, 0);
    check_eq("abort_learn_addr", b2.learn_address, 0);
    #2;
    rst2_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen += int'(b2.dec_valid);
    end
    check_eq("abort_no_decision", seen, 0);
    check_eq("abort_ready_after", b2.hdr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
